// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 main controller: steps fetch/decode/execute/memory/writeback over a shared
// datapath, handshakes with instruction and data memories, and flags illegal opcodes and timeouts.
module multicycle_control #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [10:0]      inst31_21,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic [1:0]       ALUOp,
    output logic             alu_src,
    output logic             reg2loc,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             error,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERROR
    } state_t;

    typedef enum logic [2:0] {
        C_NONE, C_LDUR, C_STUR, C_RTYPE, C_ADDI, C_CBZ, C_B
    } iclass_t;

    localparam int WAIT_W = $clog2(TIMEOUT) + 1;

    state_t            state, next_state;
    iclass_t           iclass, dec_class;
    logic [WAIT_W-1:0] wait_cnt;
    logic              retire;
    logic              waiting;
    logic              mem_ready;
    logic              timed_out;

    always_comb begin
        dec_class = C_NONE;
        casez (inst31_21)
            11'b11111000010: dec_class = C_LDUR;
            11'b11111000000: dec_class = C_STUR;
            11'b10001011000,
            11'b11001011000,
            11'b10001010000,
            11'b10101010000: dec_class = C_RTYPE;
            11'b1001000100?: dec_class = C_ADDI;
            11'b10110100???: dec_class = C_CBZ;
            11'b000101?????: dec_class = C_B;
            default:         dec_class = C_NONE;
        endcase
    end

    // The TIMEOUT-th waiting cycle is the last chance; ready arriving in that cycle still wins.
    assign waiting   = (state == S_FETCH) || (state == S_MEM);
    assign mem_ready = (state == S_FETCH) ? imem_ready : dmem_ready;
    assign timed_out = waiting && !mem_ready && (wait_cnt == WAIT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            iclass   <= C_NONE;
            wait_cnt <= '0;
            retired  <= '0;
        end else begin
            state <= next_state;
            if (state == S_DECODE)
                iclass <= dec_class;
            if (waiting && !mem_ready)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            else
                wait_cnt <= '0;
            if (retire)
                retired <= retired + CNT_W'(1);
        end
    end

    always_comb begin
        next_state = state;
        retire     = 1'b0;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ALUOp      = 2'b00;
        alu_src    = 1'b0;
        reg2loc    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        error      = 1'b0;
        case (state)
            S_IDLE: begin
                if (run)
                    next_state = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = S_DECODE;
                end else if (timed_out) begin
                    next_state = S_ERROR;
                end
            end
            S_DECODE: begin
                reg2loc    = (dec_class == C_STUR) || (dec_class == C_CBZ);
                next_state = (dec_class == C_NONE) ? S_ERROR : S_EXEC;
            end
            S_EXEC: begin
                reg2loc = (iclass == C_STUR) || (iclass == C_CBZ);
                case (iclass)
                    C_RTYPE: begin
                        ALUOp      = 2'b10;
                        next_state = S_WB;
                    end
                    C_ADDI: begin
                        alu_src    = 1'b1;
                        next_state = S_WB;
                    end
                    C_LDUR, C_STUR: begin
                        alu_src    = 1'b1;
                        next_state = S_MEM;
                    end
                    C_CBZ: begin
                        ALUOp    = 2'b01;
                        pc_write = zero;
                        pc_src   = 1'b1;
                        retire   = 1'b1;
                    end
                    C_B: begin
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                        retire   = 1'b1;
                    end
                    default: next_state = S_ERROR;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (iclass == C_STUR);
                alu_src  = 1'b1;
                reg2loc  = (iclass == C_STUR);
                if (dmem_ready) begin
                    if (iclass == C_STUR)
                        retire = 1'b1;
                    else
                        next_state = S_WB;
                end else if (timed_out) begin
                    next_state = S_ERROR;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (iclass == C_LDUR);
                retire     = 1'b1;
            end
            S_ERROR: begin
                error = 1'b1;
            end
            default: next_state = S_ERROR;
        endcase
        // A retiring instruction decides between another fetch and going idle on the run input.
        if (retire)
            next_state = run ? S_FETCH : S_IDLE;
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control, built with TIMEOUT=4 to reach timeout edges quickly.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [10:0] inst31_21;
    logic        zero;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src;
    logic [1:0]  ALUOp;
    logic        alu_src, reg2loc, reg_write, mem_to_reg, error;
    logic [31:0] retired;

    int          checks = 0;
    int          passes = 0;
    logic [12:0] exp_o;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADDI = 11'b10010001000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100000;
    localparam logic [10:0] OP_B    = 11'b00010100000;
    localparam logic [10:0] OP_BAD  = 11'b11111111111;

    multicycle_control #(.TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .inst31_21(inst31_21), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .ALUOp(ALUOp), .alu_src(alu_src), .reg2loc(reg2loc),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .error(error), .retired(retired)
    );

    always #5 clk = ~clk;

    // Packed order: imem_req dmem_req dmem_we ir_write pc_write pc_src ALUOp[1:0] alu_src reg2loc reg_write mem_to_reg error
    function automatic logic [12:0] outs();
        return {imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, ALUOp,
                alu_src, reg2loc, reg_write, mem_to_reg, error};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; inst31_21 = '0; zero = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        #1;
        exp_o = 13'b0;
        checks++; if (outs() !== exp_o) $display("[TB] FAIL reset_outs got=%b exp=%b", outs(), exp_o); else passes++;
        checks++; if (retired !== 32'd0) $display("[TB] FAIL reset_retired got=%0d exp=0", retired); else passes++;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        inst31_21 = OP_ADD; run = 1'b1; imem_ready = 1'b1;
        #1;
        exp_o = 13'b0;
        checks++; if (outs() !== exp_o) $display("[TB] FAIL add_idle got=%b exp=%b", outs(), exp_o); else passes++;
        tick(); #1;
        exp_o = 13'b1_0_0_1_1_0_00_0_0_0_0_0;
        checks++; if (outs() !== exp_o) $display("[TB] FAIL add_fetch got=%b exp=%b", outs(), exp_o); else passes++;
        tick(); #1;
        exp_o = 13'b0;
        checks++; if (outs() !== exp_o) $display("[TB] FAIL add_decode got=%b exp=%b", outs(), exp_o); else passes++;
        tick(); #1;
        exp_o = 13'b0_0_0_0_0_0_10_0_0_0_0_0;
        checks++; if (outs() !== exp_o) $display("[TB] FAIL add_exec got=%b exp=%b", outs(), exp_o); else passes++;
        tick(); #1;
        exp_o = 13'b0_0_0_0_0_0_00_0_0_1_0_0;
        checks++; if (outs() !== exp_o) $display("[TB] FAIL add_wb got=%b exp=%b", outs(), exp_o); else passes++;
        checks++; if (retired !== 32'd0) $display("[TB] FAIL add_wb_retired got=%0d exp=0", retired); else passes++;
        run = 1'b0;
        tick(); #1;
        checks++; if (retired !== 32'd1) $display("[TB] FAIL add_retired got=%0d exp=1", retired); else passes++;
        exp_o = 13'b0;
        checks++; if (outs() !== exp_o) $display("[TB] FAIL add_back_idle got=%b exp=%b", outs(), exp_o); else passes++;
    endtask

    task automatic test_ldur();
        inst31_21 = OP_LDUR; run = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b0;
        tick(); tick(); tick(); #1;
        exp_o = 13'b0_0_0_0_0_0_00_1_0_0_0_0;
        checks++; if (outs() !== exp_o) $display("[TB] FAIL ldur_exec got=%b exp=%b", outs(), exp_o); else passes++;
        exp_o = 13'b0_1_0_0_0_0_00_1_0_0_0_0;
        for (int i = 0; i < 4; i++) begin
            tick();
            dmem_ready = (i == 3);
            #1;
            checks++; if (outs() !== exp_o) $display("[TB] FAIL ldur_mem%0d got=%b exp=%b", i, outs(), exp_o); else passes++;
        end
        tick();
        dmem_ready = 1'b0;
        #1;
        exp_o = 13'b0_0_0_0_0_0_00_0_0_1_1_0;
        checks++; if (outs() !== exp_o) $display("[TB] FAIL ldur_wb got=%b exp=%b", outs(), exp_o); else passes++;
        run = 1'b0;
        tick(); #1;
        checks++; if (retired !== 32'd2) $display("[TB] FAIL ldur_retired got=%0d exp=2", retired); else passes++;
    endtask

    task automatic test_cbz();
        inst31_21 = OP_CBZ; run = 1'b1; zero = 1'b1;
        tick(); tick(); #1;
        exp_o = 13'b0_0_0_0_0_0_00_0_1_0_0_0;
        checks++; if (outs() !== exp_o) $display("[TB] FAIL cbz_decode got=%b exp=%b", outs(), exp_o); else passes++;
        tick(); #1;
        exp_o = 13'b0_0_0_0_1_1_01_0_1_0_0_0;
        checks++; if (outs() !== exp_o) $display("[TB] FAIL cbz_taken got=%b exp=%b", outs(), exp_o); else passes++;
        tick(); #1;
        checks++; if (retired !== 32'd3) $display("[TB] FAIL cbz_taken_retired got=%0d exp=3", retired); else passes++;
        exp_o = 13'b1_0_0_1_1_0_00_0_0_0_0_0;
        checks++; if (outs() !== exp_o) $display("[TB] FAIL cbz_refetch got=%b exp=%b", outs(), exp_o); else passes++;
        zero = 1'b0;
        tick(); tick(); #1;
        exp_o = 13'b0_0_0_0_0_1_01_0_1_0_0_0;
        checks++; if (outs() !== exp_o) $display("[TB] FAIL cbz_not_taken got=%b exp=%b", outs(), exp_o); else passes++;
        run = 1'b0;
        tick(); #1;
        checks++; if (retired !== 32'd4) $display("[TB] FAIL cbz_nt_retired got=%0d exp=4", retired); else passes++;
    endtask

    task automatic test_stur_run_drop();
        inst31_21 = OP_STUR; run = 1'b1; dmem_ready = 1'b0;
        tick(); tick(); tick(); #1;
        exp_o = 13'b0_0_0_0_0_0_00_1_1_0_0_0;
        checks++; if (outs() !== exp_o) $display("[TB] FAIL stur_exec got=%b exp=%b", outs(), exp_o); else passes++;
        tick();
        run = 1'b0;
        #1;
        exp_o = 13'b0_1_1_0_0_0_00_1_1_0_0_0;
        checks++; if (outs() !== exp_o) $display("[TB] FAIL stur_mem_wait got=%b exp=%b", outs(), exp_o); else passes++;
        tick();
        dmem_ready = 1'b1;
        #1;
        checks++; if (outs() !== exp_o) $display("[TB] FAIL stur_mem_ready got=%b exp=%b", outs(), exp_o); else passes++;
        tick();
        dmem_ready = 1'b0;
        #1;
        checks++; if (retired !== 32'd5) $display("[TB] FAIL stur_retired got=%0d exp=5", retired); else passes++;
        tick(); #1;
        exp_o = 13'b0;
        checks++; if (outs() !== exp_o) $display("[TB] FAIL stur_stays_idle got=%b exp=%b", outs(), exp_o); else passes++;
    endtask

    task automatic test_back_to_back();
        inst31_21 = OP_B; run = 1'b1;
        tick(); tick(); tick(); #1;
        exp_o = 13'b0_0_0_0_1_1_00_0_0_0_0_0;
        checks++; if (outs() !== exp_o) $display("[TB] FAIL b_exec got=%b exp=%b", outs(), exp_o); else passes++;
        inst31_21 = OP_ADDI;
        tick(); #1;
        checks++; if (retired !== 32'd6) $display("[TB] FAIL b_retired got=%0d exp=6", retired); else passes++;
        tick(); tick(); #1;
        exp_o = 13'b0_0_0_0_0_0_00_1_0_0_0_0;
        checks++; if (outs() !== exp_o) $display("[TB] FAIL addi_exec got=%b exp=%b", outs(), exp_o); else passes++;
        tick(); #1;
        exp_o = 13'b0_0_0_0_0_0_00_0_0_1_0_0;
        checks++; if (outs() !== exp_o) $display("[TB] FAIL addi_wb got=%b exp=%b", outs(), exp_o); else passes++;
        run = 1'b0;
        tick(); #1;
        checks++; if (retired !== 32'd7) $display("[TB] FAIL addi_retired got=%0d exp=7", retired); else passes++;
    endtask

    task automatic test_reset_mid_mem();
        inst31_21 = OP_STUR; run = 1'b1; dmem_ready = 1'b0;
        tick(); tick(); tick(); tick(); #1;
        exp_o = 13'b0_1_1_0_0_0_00_1_1_0_0_0;
        checks++; if (outs() !== exp_o) $display("[TB] FAIL midmem_pre got=%b exp=%b", outs(), exp_o); else passes++;
        rst_n = 1'b0;
        #1;
        exp_o = 13'b0;
        checks++; if (outs() !== exp_o) $display("[TB] FAIL midmem_reset got=%b exp=%b", outs(), exp_o); else passes++;
        checks++; if (retired !== 32'd0) $display("[TB] FAIL midmem_retired got=%0d exp=0", retired); else passes++;
        run = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_ready_last_cycle();
        inst31_21 = OP_ADD; run = 1'b1; imem_ready = 1'b0;
        tick();
        exp_o = 13'b1_0_0_0_0_0_00_0_0_0_0_0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (outs() !== exp_o) $display("[TB] FAIL late_fetch%0d got=%b exp=%b", i, outs(), exp_o); else passes++;
            tick();
        end
        imem_ready = 1'b1;
        #1;
        exp_o = 13'b1_0_0_1_1_0_00_0_0_0_0_0;
        checks++; if (outs() !== exp_o) $display("[TB] FAIL late_fetch_ready got=%b exp=%b", outs(), exp_o); else passes++;
        tick(); #1;
        exp_o = 13'b0;
        checks++; if (outs() !== exp_o) $display("[TB] FAIL late_decode got=%b exp=%b", outs(), exp_o); else passes++;
        tick(); tick();
        run = 1'b0;
        tick(); #1;
        checks++; if (retired !== 32'd1) $display("[TB] FAIL late_retired got=%0d exp=1", retired); else passes++;
    endtask

    task automatic test_timeout();
        run = 1'b1; imem_ready = 1'b0;
        tick();
        exp_o = 13'b1_0_0_0_0_0_00_0_0_0_0_0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (outs() !== exp_o) $display("[TB] FAIL to_fetch%0d got=%b exp=%b", i, outs(), exp_o); else passes++;
            tick();
        end
        #1;
        exp_o = 13'b0_0_0_0_0_0_00_0_0_0_0_1;
        checks++; if (outs() !== exp_o) $display("[TB] FAIL to_error got=%b exp=%b", outs(), exp_o); else passes++;
        imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            checks++; if (outs() !== exp_o) $display("[TB] FAIL to_sticky%0d got=%b exp=%b", i, outs(), exp_o); else passes++;
        end
        checks++; if (retired !== 32'd1) $display("[TB] FAIL to_retired got=%0d exp=1", retired); else passes++;
        rst_n = 1'b0;
        #1;
        exp_o = 13'b0;
        checks++; if (outs() !== exp_o) $display("[TB] FAIL to_cleared got=%b exp=%b", outs(), exp_o); else passes++;
        run = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_illegal();
        inst31_21 = OP_BAD; run = 1'b1; imem_ready = 1'b1;
        tick(); tick(); #1;
        exp_o = 13'b0;
        checks++; if (outs() !== exp_o) $display("[TB] FAIL bad_decode got=%b exp=%b", outs(), exp_o); else passes++;
        exp_o = 13'b0_0_0_0_0_0_00_0_0_0_0_1;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            checks++; if (outs() !== exp_o) $display("[TB] FAIL bad_error%0d got=%b exp=%b", i, outs(), exp_o); else passes++;
        end
        checks++; if (retired !== 32'd0) $display("[TB] FAIL bad_retired got=%0d exp=0", retired); else passes++;
        rst_n = 1'b0;
        #1;
        checks++; if (error !== 1'b0) $display("[TB] FAIL bad_reset_error got=%b exp=0", error); else passes++;
        run = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_ldur();
        test_cbz();
        test_stur_run_drop();
        test_back_to_back();
        test_reset_mid_mem();
        test_ready_last_cycle();
        test_timeout();
        test_illegal();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
